// File: rtl/pipelined_logic_pkg.sv
// rtl/pipelined_logic_pkg.sv - shared op-codes for the pipelined logic unit
package pipelined_logic_pkg;

    localparam int OP_W = 2;

    localparam logic [OP_W-1:0] OP_AND  = 2'b00;
    localparam logic [OP_W-1:0] OP_OR   = 2'b01;
    localparam logic [OP_W-1:0] OP_XOR  = 2'b10;
    localparam logic [OP_W-1:0] OP_XNOR = 2'b11;

endpackage

// File: rtl/logic_slice.sv
// rtl/logic_slice.sv - one-bit gate-level AND/OR/XOR/XNOR cell
module logic_slice
    import pipelined_logic_pkg::*;
(
    input  logic            a,
    input  logic            b,
    input  logic [OP_W-1:0] op,
    output logic            y
);

    logic and_y;
    logic or_y;
    logic xor_y;
    logic xfam_y;

    and g_and (and_y, a, b);
    or  g_or  (or_y,  a, b);
    xor g_xor (xor_y, a, b);
    // op[0] turns XOR into XNOR; op[1] picks the XOR family over AND/OR
    xor g_inv (xfam_y, xor_y, op[0]);

    assign y = op[1] ? xfam_y : (op[0] ? or_y : and_y);

endmodule

// File: rtl/pipelined_logic_unit.sv
// rtl/pipelined_logic_unit.sv - two-stage bitwise logic unit with ZF/SF flags
// Optional even-parity output out_pf when PIPELINED_LOGIC_PARITY_EN is defined.
module pipelined_logic_unit
    import pipelined_logic_pkg::*;
#(
    parameter int               WIDTH        = 64,
    parameter logic [WIDTH-1:0] RESET_RESULT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OP_W-1:0]  in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zf,
    output logic             out_sf
`ifdef PIPELINED_LOGIC_PARITY_EN
    ,
    output logic             out_pf
`endif
);

    logic             s1_valid;
    logic             s2_valid;
    logic             s2_adv;
    logic             in_fire;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [OP_W-1:0]  s1_op;
    logic [WIDTH-1:0] op_y;

    // in_ready depends only on state and out_ready, never on in_valid
    assign s2_adv    = s1_valid && (!s2_valid || out_ready);
    assign in_ready  = !s1_valid || s2_adv;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = s2_valid;

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        logic_slice u_slice (
            .a  (s1_a[i]),
            .b  (s1_b[i]),
            .op (s1_op),
            .y  (op_y[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_a     <= in_a;
            s1_b     <= in_b;
            s1_op    <= in_op;
        end else if (s2_adv) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            out_result <= RESET_RESULT;
            out_zf     <= 1'b0;
            out_sf     <= 1'b0;
`ifdef PIPELINED_LOGIC_PARITY_EN
            out_pf     <= 1'b0;
`endif
        end else if (flush) begin
            s2_valid <= 1'b0;
        end else if (s2_adv) begin
            s2_valid   <= 1'b1;
            out_result <= op_y;
            out_zf     <= ~|op_y;
            out_sf     <= op_y[WIDTH-1];
`ifdef PIPELINED_LOGIC_PARITY_EN
            out_pf     <= ^op_y;
`endif
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pipelined_logic_unit.sv
// tb/tb_pipelined_logic_unit.sv - scoreboard bench for pipelined_logic_unit
module tb_pipelined_logic_unit;

    localparam int          W       = 64;
    localparam logic [W-1:0] RST_VAL = 64'hA5A5_5A5A_0123_4567;

    typedef struct packed {
        logic [W-1:0] r;
        logic         zf;
        logic         sf;
        logic         pf;
    } exp_t;

    logic         clk       = 1'b0;
    logic         rst       = 1'b0;
    logic         flush     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a      = '0;
    logic [W-1:0] in_b      = '0;
    logic [1:0]   in_op     = 2'b00;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_result;
    logic         out_zf;
    logic         out_sf;
`ifdef PIPELINED_LOGIC_PARITY_EN
    logic         out_pf;
`endif

    int   checks = 0;
    int   errors = 0;
    int   n_out  = 0;
    exp_t q[$];
    exp_t sb_e;

    pipelined_logic_unit #(.WIDTH(W), .RESET_RESULT(RST_VAL)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zf     (out_zf),
        .out_sf     (out_sf)
`ifdef PIPELINED_LOGIC_PARITY_EN
        ,
        .out_pf     (out_pf)
`endif
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
        exp_t e;
        case (op)
            2'b00:   e.r = a & b;
            2'b01:   e.r = a | b;
            2'b10:   e.r = a ^ b;
            default: e.r = ~(a ^ b);
        endcase
        e.zf = (e.r == '0);
        e.sf = e.r[W-1];
        e.pf = ^e.r;
        return e;
    endfunction

    // Scoreboard: inputs pushed on handshake, outputs popped on handshake.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected result %h with empty scoreboard", out_result);
                end else begin
                    sb_e = q.pop_front();
                    n_out++;
                    if (out_result !== sb_e.r || out_zf !== sb_e.zf || out_sf !== sb_e.sf
`ifdef PIPELINED_LOGIC_PARITY_EN
                        || out_pf !== sb_e.pf
`endif
                       ) begin
                        errors++;
                        $display("FAIL sb_result got %h zf%0b sf%0b exp %h zf%0b sf%0b",
                                 out_result, out_zf, out_sf, sb_e.r, sb_e.zf, sb_e.sf);
                    end
                end
            end
            if (flush) q.delete();
            else if (in_valid && in_ready) q.push_back(model(in_a, in_b, in_op));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
        in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        #2;
        checks++;
        if (out_valid !== 1'b0 || out_result !== RST_VAL || out_zf !== 1'b0 || out_sf !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got v%0b %h zf%0b sf%0b exp v0 %h zf0 sf0",
                     out_valid, out_result, out_zf, out_sf, RST_VAL);
        end
        tick; tick;
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
        tick;
    endtask

    task automatic test_single;
        out_ready = 1'b1;
        drive(64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F, 2'b10);
        tick;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early got %0b exp 0", out_valid); end
        tick;
        checks++;
        if (out_valid !== 1'b1 || out_result !== 64'hF0F0_0F0F_F0F0_0F0F || out_zf !== 1'b0 || out_sf !== 1'b1) begin
            errors++;
            $display("FAIL single_result got v%0b %h zf%0b sf%0b exp v1 f0f00f0ff0f00f0f zf0 sf1",
                     out_valid, out_result, out_zf, out_sf);
        end
        tick;
        checks++;
        if (out_valid !== 1'b0 || out_result !== 64'hF0F0_0F0F_F0F0_0F0F) begin
            errors++;
            $display("FAIL single_after got v%0b %h exp v0 f0f00f0ff0f00f0f", out_valid, out_result);
        end
    endtask

    task automatic test_zero_flag;
        out_ready = 1'b1;
        drive(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 2'b10);
        tick;
        in_op = 2'b11;
        tick;
        in_valid = 1'b0;
        checks++;
        if (out_result !== 64'h0 || out_zf !== 1'b1 || out_sf !== 1'b0) begin
            errors++;
            $display("FAIL zero_xor got %h zf%0b sf%0b exp 0 zf1 sf0", out_result, out_zf, out_sf);
        end
        tick;
        checks++;
        if (out_result !== {W{1'b1}} || out_zf !== 1'b0 || out_sf !== 1'b1) begin
            errors++;
            $display("FAIL zero_xnor got %h zf%0b sf%0b exp all-ones zf0 sf1", out_result, out_zf, out_sf);
        end
        tick;
    endtask

    task automatic test_back_to_back;
        int n0;
        n0 = n_out;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive({$urandom, $urandom}, {$urandom, $urandom}, i[1:0]);
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready op %0d got %0b exp 1", i, in_ready); end
            if (i >= 2) begin
                checks++;
                if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_stream op %0d out_valid got %0b exp 1", i, out_valid); end
            end
            tick;
        end
        in_valid = 1'b0;
        tick; tick;
        checks++;
        if (q.size() != 0 || n_out - n0 != 8 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_count got %0d outputs %0d pending v%0b exp 8 0 v0", n_out - n0, q.size(), out_valid);
        end
    endtask

    task automatic test_backpressure;
        int           n0;
        int           budget;
        logic [W-1:0] held;
        logic         hz;
        logic         hs;
        n0 = n_out;
        out_ready = 1'b0;
        drive({$urandom, $urandom}, {$urandom, $urandom}, 2'b00);
        tick;
        drive({$urandom, $urandom}, {$urandom, $urandom}, 2'b01);
        tick;
        drive({$urandom, $urandom}, {$urandom, $urandom}, 2'b11);
        checks++;
        if (in_ready !== 1'b0 || q.size() != 2) begin
            errors++;
            $display("FAIL bp_full got in_ready %0b buffered %0d exp 0 2", in_ready, q.size());
        end
        held = out_result; hz = out_zf; hs = out_sf;
        repeat (5) begin
            tick;
            checks++;
            if (out_valid !== 1'b1 || out_result !== held || out_zf !== hz || out_sf !== hs || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold got v%0b %h rdy%0b exp v1 %h rdy0", out_valid, out_result, in_ready, held);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release in_ready got %0b exp 1", in_ready); end
        tick;
        drive({$urandom, $urandom}, {$urandom, $urandom}, 2'b10);
        tick;
        in_valid = 1'b0;
        budget = 0;
        while (q.size() != 0 && budget < 20) begin tick; budget++; end
        tick;
        checks++;
        if (q.size() != 0 || n_out - n0 != 4) begin
            errors++;
            $display("FAIL bp_count got %0d outputs %0d pending exp 4 0", n_out - n0, q.size());
        end
    endtask

    task automatic test_flush;
        int   n0;
        exp_t ed;
        n0 = n_out;
        out_ready = 1'b1;
        drive(64'h1111_2222_3333_4444, 64'h0F0F_0000_FFFF_0000, 2'b00);
        tick;
        drive(64'hDEAD_BEEF_0000_0001, 64'h0000_0000_FFFF_FFFF, 2'b10);
        tick;
        drive(64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001, 2'b01);
        flush = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_pre got in_ready %0b out_valid %0b exp 1 1", in_ready, out_valid);
        end
        tick;
        flush = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || q.size() != 0 || n_out - n0 != 1) begin
            errors++;
            $display("FAIL flush_kill got v%0b pending %0d outputs %0d exp v0 0 1", out_valid, q.size(), n_out - n0);
        end
        drive(64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_0000_0000, 2'b11);
        ed = model(in_a, in_b, in_op);
        tick;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_next_early got %0b exp 0", out_valid); end
        tick;
        checks++;
        if (out_valid !== 1'b1 || out_result !== ed.r) begin
            errors++;
            $display("FAIL flush_next got v%0b %h exp v1 %h", out_valid, out_result, ed.r);
        end
        tick;
        checks++;
        if (n_out - n0 != 2) begin errors++; $display("FAIL flush_count got %0d exp 2", n_out - n0); end
    endtask

    task automatic test_async_reset;
        out_ready = 1'b0;
        drive(64'h0, 64'h0, 2'b11);
        tick;
        in_valid = 1'b0;
        tick;
        checks++;
        if (out_valid !== 1'b1 || out_sf !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre got v%0b sf%0b exp v1 sf1", out_valid, out_sf);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_sf !== 1'b0 || out_zf !== 1'b0 || out_result !== RST_VAL || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL areset_drop got v%0b %h zf%0b sf%0b rdy%0b exp v0 %h zf0 sf0 rdy1",
                     out_valid, out_result, out_zf, out_sf, in_ready, RST_VAL);
        end
        tick;
        rst = 1'b0;
        out_ready = 1'b1;
        tick;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_after got %0b exp 0", out_valid); end
    endtask

`ifdef PIPELINED_LOGIC_PARITY_EN
    task automatic test_parity;
        out_ready = 1'b1;
        drive(64'h7, 64'h0, 2'b01);
        tick;
        in_valid = 1'b0;
        tick;
        checks++;
        if (out_valid !== 1'b1 || out_pf !== 1'b1) begin
            errors++;
            $display("FAIL parity got v%0b pf%0b exp v1 pf1", out_valid, out_pf);
        end
        tick;
    endtask
`endif

    initial begin
        test_reset;
        test_single;
        test_zero_flag;
        test_back_to_back;
        test_backpressure;
        test_flush;
        test_async_reset;
`ifdef PIPELINED_LOGIC_PARITY_EN
        test_parity;
`endif
        tick; tick;
        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL final_drain got %0d pending exp 0", q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
